reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rs  input  ADDR_W  read address, port A.
REQ-007 SHALL have port rs2  input  ADDR_W  read address, port B.
REQ-008 SHALL have port wr_en  input  1  write strobe.
REQ-009 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-010 SHALL have port busW  input  DATA_W  write data.
REQ-011 SHALL have port iss_en  input  1  issue strobe; marks iss_dst pending.
REQ-012 SHALL have port iss_dst  input  ADDR_W  destination register being issued.
REQ-013 SHALL have port clr_req  input  1  bulk-clear request.
REQ-014 SHALL have port busA  output  DATA_W  read data, port A (combinational).
REQ-015 SHALL have port busB  output  DATA_W  read data, port B (combinational).
REQ-016 SHALL have port hazA  output  1  pending bit of rs after same-cycle bypass.
REQ-017 SHALL have port hazB  output  1  pending bit of rs2 after same-cycle bypass.
REQ-018 SHALL have port busy  output  1  bulk clear in progress.

Function
REQ-019 SHALL write busW to wr_addr at the clock edge when wr_en=1 and busy=0.
REQ-020 SHALL return busW on busA/busB in the same cycle when wr_en=1, busy=0 and wr_addr equals the read address (write-through bypass).
REQ-021 SHALL, with ZERO_REG=1, ignore writes and issues to address 0, read 0 on address 0, and never raise haz for address 0.
REQ-022 SHALL keep one pending bit per register; iss_en=1 with busy=0 sets pending[iss_dst]; accepted write clears pending[wr_addr].
REQ-023 SHALL leave pending set when iss_en and an accepted write target the same address in one cycle (new issue wins).
REQ-024 SHALL drive hazA = pending[rs] AND NOT (accepted write to rs this cycle); hazB likewise for rs2.
REQ-025 SHALL, on clr_req=1 while busy=0, clear all pending bits at that edge, assert busy from the next cycle and run counter states IDLE -> CLEAR -> IDLE.
REQ-026 SHALL in CLEAR zero one register per cycle, starting at 1 (ZERO_REG=1) or 0 (ZERO_REG=0), ascending, and return to IDLE after the last index DEPTH-1.
REQ-027 SHALL therefore hold busy for DEPTH-1 cycles (ZERO_REG=1) or DEPTH cycles (ZERO_REG=0).
REQ-028 SHALL ignore wr_en, iss_en and clr_req while busy=1; no bypass while busy; reads return stored contents, with registers not yet cleared showing old data.
REQ-029 SHALL treat an edge where clr_req and wr_en/iss_en are all 1 with busy=0 as clear-only; the write and issue are dropped.
REQ-030 SHALL count with an ADDR_W-bit counter without wrap past DEPTH-1.

Reset
REQ-031 SHALL, while reset=0, asynchronously force all registers to 0, all pending bits to 0, state to IDLE and busy to 0.
REQ-032 SHALL abort a bulk clear in progress on reset assertion; after release, no clear resumes.
REQ-033 SHALL accept wr_en/iss_en at the first rising edge after reset deasserts.

Verification
REQ-034 SHALL cover write 0xDEADBEEF to r5, read rs=5 same cycle -> busA=0xDEADBEEF (bypass); next cycle still 0xDEADBEEF.
REQ-035 SHALL cover write 0x12345678 to r0 with ZERO_REG=1 -> busA=0 when rs=0, and issue r0 -> hazA=0.
REQ-036 SHALL cover issue r7 -> hazB=1 with rs2=7; write r7 -> hazB=0 in the write cycle; issue and write r7 in the same cycle -> hazB=1 next cycle.
REQ-037 SHALL cover r3=0xA5A5A5A5, pulse clr_req (ADDR_W=5) -> busy=1 for exactly 31 cycles, writes during busy dropped, and every register reads 0 afterwards.
REQ-038 SHALL cover asserting reset=0 mid-clear, cycle 10 -> busy=0 immediately, all registers 0, all haz 0.
REQ-039 SHALL cover wr_en, iss_en and clr_req together (r9) -> clear runs; r9 reads 0 and is not pending.

Source files
------------

// File: rtl/reg_file_sb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reg_file_sb : two-read/one-write register file with a pending-bit   |
// |               scoreboard and a one-register-per-cycle bulk clear    |
// | Revision    : 1.0                                                   |
// +--------------------------------------------------------------------+
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] busW,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_dst,
  input  logic              clr_req,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  output logic              hazA,
  output logic              hazB,
  output logic              busy
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] c_first_idx = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] c_last_idx  = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_pend;

  logic w_zero_wr;
  logic w_zero_iss;
  logic w_clr_acc;
  logic w_wr_acc;
  logic w_iss_acc;
  logic w_byp_a;
  logic w_byp_b;
  logic w_zero_rs;
  logic w_zero_rs2;

  assign busy       = (r_state == ST_CLEAR);
  assign w_zero_wr  = (ZERO_REG != 0) && (wr_addr == '0);
  assign w_zero_iss = (ZERO_REG != 0) && (iss_dst == '0);
  assign w_zero_rs  = (ZERO_REG != 0) && (rs == '0);
  assign w_zero_rs2 = (ZERO_REG != 0) && (rs2 == '0);

  // A clear request wins over a write or issue in the same cycle.
  assign w_clr_acc = clr_req && !busy;
  assign w_wr_acc  = wr_en && !busy && !clr_req && !w_zero_wr;
  assign w_iss_acc = iss_en && !busy && !clr_req && !w_zero_iss;

  assign w_byp_a = w_wr_acc && (wr_addr == rs);
  assign w_byp_b = w_wr_acc && (wr_addr == rs2);

  assign busA = w_zero_rs  ? '0 : (w_byp_a ? busW : r_regs[rs]);
  assign busB = w_zero_rs2 ? '0 : (w_byp_b ? busW : r_regs[rs2]);
  assign hazA = r_pend[rs]  && !w_byp_a;
  assign hazB = r_pend[rs2] && !w_byp_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_clr_acc) w_state_next = ST_CLEAR;
      ST_CLEAR: if (r_cnt == c_last_idx) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_clr_acc) begin
      r_cnt <= c_first_idx;
    end else if (busy && (r_cnt != c_last_idx)) begin
      r_cnt <= r_cnt + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (busy) begin
      r_regs[r_cnt] <= '0;
    end else if (w_wr_acc) begin
      r_regs[wr_addr] <= busW;
    end
  end

  // Issue is applied after the write so a same-address issue stays pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
    end else if (w_clr_acc) begin
      r_pend <= '0;
    end else begin
      if (w_wr_acc)  r_pend[wr_addr] <= 1'b0;
      if (w_iss_acc) r_pend[iss_dst] <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_reg_file_sb : directed and randomized bench for reg_file_sb      |
// | Revision       : 1.0                                                |
// +--------------------------------------------------------------------+
module tb_reg_file_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int ZR    = 1;
  localparam int DEPTH = 1 << AW;
  localparam int FIRST = (ZR != 0) ? 1 : 0;

  logic          clk     = 1'b0;
  logic          reset   = 1'b1;
  logic [AW-1:0] rs      = '0;
  logic [AW-1:0] rs2     = '0;
  logic          wr_en   = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] busW    = '0;
  logic          iss_en  = 1'b0;
  logic [AW-1:0] iss_dst = '0;
  logic          clr_req = 1'b0;
  logic [DW-1:0] busA;
  logic [DW-1:0] busB;
  logic          hazA;
  logic          hazB;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Reference model: plain storage, pending flags and a queue of
  // register indices still waiting to be zeroed by the bulk clear.
  logic [DW-1:0]    m_mem [DEPTH];
  logic [DEPTH-1:0] m_pend;
  int               m_clr_q [$];

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR)) dut (
    .clk(clk), .reset(reset), .rs(rs), .rs2(rs2), .wr_en(wr_en),
    .wr_addr(wr_addr), .busW(busW), .iss_en(iss_en), .iss_dst(iss_dst),
    .clr_req(clr_req), .busA(busA), .busB(busB), .hazA(hazA),
    .hazB(hazB), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_busy();
    return m_clr_q.size() != 0;
  endfunction

  function automatic logic m_wr_acc();
    return reset && !m_busy() && wr_en && !clr_req && !((ZR != 0) && (wr_addr == '0));
  endfunction

  function automatic logic m_iss_acc();
    return reset && !m_busy() && iss_en && !clr_req && !((ZR != 0) && (iss_dst == '0));
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if ((ZR != 0) && (a == '0)) return '0;
    if (m_wr_acc() && (wr_addr == a)) return busW;
    return m_mem[a];
  endfunction

  function automatic logic m_haz(input logic [AW-1:0] a);
    return m_pend[a] && !(m_wr_acc() && (wr_addr == a));
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_pend = '0;
      m_clr_q.delete();
    end else if (m_busy()) begin
      m_mem[m_clr_q.pop_front()] = '0;
    end else if (clr_req) begin
      m_pend = '0;
      for (int i = FIRST; i < DEPTH; i++) m_clr_q.push_back(i);
    end else begin
      if (m_wr_acc()) begin
        m_mem[wr_addr]  = busW;
        m_pend[wr_addr] = 1'b0;
      end
      if (m_iss_acc()) m_pend[iss_dst] = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("model_busA", busA, m_read(rs));
    check("model_busB", busB, m_read(rs2));
    check("model_hazA", DW'(hazA), DW'(m_haz(rs)));
    check("model_hazB", DW'(hazB), DW'(m_haz(rs2)));
    check("model_busy", DW'(busy), DW'(m_busy()));
  end

  task automatic idle();
    wr_en   = 1'b0;
    iss_en  = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic i, input logic [AW-1:0] id, input logic c,
                       input logic [AW-1:0] a, input logic [AW-1:0] b);
    @(posedge clk);
    #1;
    wr_en = w; wr_addr = wa; busW = wd;
    iss_en = i; iss_dst = id; clr_req = c;
    rs = a; rs2 = b;
    #1;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 3) != 0) return AW'($urandom_range(0, 7));
    return AW'($urandom());
  endfunction

  initial begin
    int n;
    int rst_hold;
    rst_hold = 0;
    rs = 5'd5;
    #1 reset = 1'b0;
    #2;
    check("reset_busy", DW'(busy), '0);
    check("reset_busA", busA, '0);
    check("reset_hazA", DW'(hazA), '0);
    @(posedge clk);
    #1 reset = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd5; busW = 32'hDEADBEEF; rs = 5'd5;
    #1;
    check("bypass_r5", busA, 32'hDEADBEEF);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
    check("hold_r5", busA, 32'hDEADBEEF);

    drive(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    check("r0_write_cycle", busA, '0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    check("r0_read", busA, '0);
    check("r0_haz", DW'(hazA), '0);

    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0, 5'd7);
    check("r7_issue_cycle", DW'(hazB), '0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
    check("r7_pending", DW'(hazB), 32'd1);
    drive(1'b1, 5'd7, 32'h00000777, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
    check("r7_write_cycle", DW'(hazB), '0);
    check("r7_write_bypass", busB, 32'h00000777);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
    check("r7_cleared", DW'(hazB), '0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0, 5'd7);
    drive(1'b1, 5'd7, 32'h00000888, 1'b1, 5'd7, 1'b0, 5'd0, 5'd7);
    check("r7_wr_iss_cycle", DW'(hazB), '0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
    check("r7_issue_wins", DW'(hazB), 32'd1);
    check("r7_data", busB, 32'h00000888);

    drive(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd3, 5'd0);
    check("clr_req_cycle_busy", DW'(busy), '0);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      drive(1'b1, AW'(k % 31 + 1), 32'hFFFFFFFF, 1'b1, 5'd2, 1'b1, 5'd3, 5'd2);
      if (!busy) begin
        idle();
        break;
      end
      n++;
    end
    check("clear_busy_cycles", DW'(n), 32'd31);
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, AW'(a), AW'(a));
      check("cleared_reg", busA, '0);
      check("cleared_haz", DW'(hazA), '0);
    end

    drive(1'b1, 5'd20, 32'h00000055, 1'b0, 5'd0, 1'b0, 5'd20, 5'd25);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd20, 5'd25);
    for (int k = 0; k < 10; k++) drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd20, 5'd25);
    check("mid_clear_busy", DW'(busy), 32'd1);
    check("mid_clear_r20_old", busA, 32'h00000055);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_busy", DW'(busy), '0);
    for (int a = 0; a < DEPTH; a++) begin
      rs = AW'(a); rs2 = AW'(a);
      #1;
      check("abort_reg", busA, '0);
      check("abort_hazA", DW'(hazA), '0);
      check("abort_hazB", DW'(hazB), '0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd20, 5'd25);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd20, 5'd25);
    check("no_resume_busy", DW'(busy), '0);

    drive(1'b1, 5'd9, 32'h00000099, 1'b0, 5'd0, 1'b0, 5'd9, 5'd9);
    drive(1'b1, 5'd9, 32'h00001234, 1'b1, 5'd9, 1'b1, 5'd9, 5'd9);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd9);
      if (!busy) break;
      n++;
    end
    check("combo_busy_cycles", DW'(n), 32'd31);
    check("combo_r9", busA, '0);
    check("combo_r9_haz", DW'(hazA), '0);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) reset = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        idle();
        reset = 1'b0;
        rst_hold = int'($urandom_range(1, 3));
      end
      if (rst_hold == 0) begin
        wr_en   = ($urandom_range(0, 1) == 1);
        iss_en  = ($urandom_range(0, 2) == 0);
        clr_req = ($urandom_range(0, 59) == 0);
        wr_addr = pick_addr();
        iss_dst = pick_addr();
        busW    = $urandom();
        case ($urandom_range(0, 2))
          0:       rs = wr_addr;
          1:       rs = iss_dst;
          default: rs = pick_addr();
        endcase
        case ($urandom_range(0, 2))
          0:       rs2 = wr_addr;
          1:       rs2 = iss_dst;
          default: rs2 = pick_addr();
        endcase
      end
    end

    @(posedge clk);
    #1;
    idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
